// File: rtl/f2s_pkg.sv
// f2s_pkg: shared types and constants for the FPGA-to-SDRAM burst writer.
//   state_e     - writer FSM states (IDLE/AW/W/B/DONE)
//   SIZE_32B, BURST_INCR, RESP_OKAY, CACHE_BUF_MOD - fixed AXI3 field values
//   MAX_BEATS   - longest AXI3 INCR burst
//   BEATS_PER_4K - 32-byte beats in one 4 KB page
//   calc_burst() - beats in the next burst, clipped to 16, the remaining
//                  count and the distance to the next 4 KB boundary
package f2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [2:0] SIZE_32B      = 3'b101;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

    localparam int unsigned MAX_BEATS    = 16;
    localparam int unsigned BEATS_PER_4K = 128;

    // word_in_4k is addr[11:5]; 128 - word_in_4k is always 1..128.
    function automatic logic [4:0] calc_burst(input logic [26:0] remaining,
                                              input logic [6:0]  word_in_4k);
        logic [7:0] to_boundary;
        logic [4:0] beats;
        to_boundary = 8'(BEATS_PER_4K) - {1'b0, word_in_4k};
        beats       = 5'(MAX_BEATS);
        if (remaining < 27'(MAX_BEATS)) begin
            beats = remaining[4:0];
        end
        if (to_boundary < {3'b000, beats}) begin
            beats = to_boundary[4:0];
        end
        return beats;
    endfunction

endpackage

// File: rtl/f2s_axi_burst_writer_fifo.sv
// f2s_beat_fifo: two-beat prefetch buffer between a 1-cycle-latency BRAM
// and the AXI W channel.
//   clk, reset_n - clock, asynchronous active-low reset
//   fetch_ok     - the owner still wants beats for the current burst
//   pop          - head beat consumed this cycle (only while avail=1)
//   bram_rdata   - BRAM data, valid the cycle after rd_issue
//   rd_issue     - a BRAM read is issued this cycle (owner advances address)
//   avail        - at least one beat is stored or arriving this cycle
//   head         - oldest beat; bypasses straight from BRAM when empty
//
// The read in flight counts as occupying a slot, so a read is issued only
// when stored + in-flight - popping leaves a slot free for it. With a pop
// every cycle this still issues every cycle, sustaining one beat per cycle.
module f2s_beat_fifo #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_ok,
    input  logic              pop,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              rd_issue,
    output logic              avail,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] entry0_q, entry0_d;
    logic [DATA_W-1:0] entry1_q, entry1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              pend_q, pend_d;

    logic              stored_pop;
    logic              bypass_pop;
    logic              push;
    logic [2:0]        committed;

    always_comb begin
        entry0_d   = entry0_q;
        entry1_d   = entry1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        avail      = (count_q != 2'd0) || pend_q;
        head       = (count_q != 2'd0) ? (rd_ptr_q ? entry1_q : entry0_q) : bram_rdata;

        // An empty buffer hands the arriving BRAM word straight out; it is
        // only stored if nobody takes it this cycle.
        stored_pop = pop && (count_q != 2'd0);
        bypass_pop = pop && (count_q == 2'd0);
        push       = pend_q && !bypass_pop;

        committed  = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
        rd_issue   = fetch_ok && (committed < 3'd2);
        pend_d     = rd_issue;

        if (push) begin
            if (wr_ptr_q) begin
                entry1_d = bram_rdata;
            end else begin
                entry0_d = bram_rdata;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (stored_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, stored_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            pend_q   <= 1'b0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/f2s_axi_burst_writer.sv
// f2s_axi_burst_writer: copies a block of DATA_W-bit BRAM words (from word 0
// upward) to HPS SDRAM over the f2h_sdram0 AXI3 write channels, splitting it
// into INCR bursts of at most 16 beats that never cross a 4 KB page.
//   clk, reset_n          - clock, asynchronous active-low reset
//   start                 - rising edge starts a transfer (from PIO)
//   start_addr, xfer_len  - byte address / byte length, bits [4:0] ignored
//   done, busy, error     - status back to PIO; error is sticky per transfer
//   stat_beats/stat_cycles- only with F2S_WRITER_STATS_EN: W handshakes and
//                           busy cycles since the last accepted start
//   bram_addr, bram_rdata - BRAM read port, 1-cycle latency
//   aw*, w*, b*           - AXI3 write address / data / response channels
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. awvalid and wvalid come only from registered state, never from
// awready/wready, and once raised they stay high with a stable payload until
// that edge. bready is high for the whole B state. Only one burst is in
// flight, and AW always completes before its W beats start.
module f2s_axi_burst_writer
    import f2s_pkg::*;
#(
    parameter int         DATA_W  = 256,
    parameter int         ADDR_W  = 32,
    parameter int         BRAM_AW = 10,
    parameter logic [7:0] AXI_ID  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           start_addr,
    input  logic [31:0]           xfer_len,
    output logic                  done,
    output logic                  busy,
    output logic                  error,
`ifdef F2S_WRITER_STATS_EN
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_cycles,
`endif
    output logic [BRAM_AW-1:0]    bram_addr,
    input  logic [DATA_W-1:0]     bram_rdata,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awlen,
    output logic [7:0]            awid,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [2:0]            awprot,
    output logic [3:0]            awcache,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    output logic [7:0]            wid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic [7:0]            bid,
    input  logic                  bvalid,
    output logic                  bready
);

    state_e               state_q, state_d;
    logic                 start_q, start_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [26:0]          remaining_q, remaining_d;
    logic [4:0]           burst_q, burst_d;
    logic [4:0]           beat_cnt_q, beat_cnt_d;
    logic [4:0]           rd_left_q, rd_left_d;
    logic [BRAM_AW-1:0]   rd_addr_q, rd_addr_d;
    logic                 error_q, error_d;

    logic                 start_edge;
    logic                 accept_start;
    logic [26:0]          total_beats;
    logic [26:0]          rem_next;
    logic [ADDR_W-1:0]    addr_next;
    logic                 fetch_ok;
    logic                 rd_issue;
    logic                 fifo_avail;
    logic [DATA_W-1:0]    fifo_head;
    logic                 w_pop;
    logic                 last_beat;
    logic                 unused_inputs;

    assign unused_inputs = ^{bid, start_addr[4:0], xfer_len[4:0]};

    f2s_beat_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_ok   (fetch_ok),
        .pop        (w_pop),
        .bram_rdata (bram_rdata),
        .rd_issue   (rd_issue),
        .avail      (fifo_avail),
        .head       (fifo_head)
    );

    // Status and channel controls decode directly from registered state.
    always_comb begin
        awvalid   = (state_q == ST_AW);
        wvalid    = (state_q == ST_W) && fifo_avail;
        bready    = (state_q == ST_B);
        busy      = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B);
        done      = (state_q == ST_DONE);
        error     = error_q;
        last_beat = (beat_cnt_q == (burst_q - 5'd1));
        w_pop     = wvalid && wready;
        // Prefetch begins as soon as the burst's AW is presented.
        fetch_ok  = ((state_q == ST_AW) || (state_q == ST_W)) && (rd_left_q != 5'd0);

        awaddr    = awvalid ? addr_q : '0;
        awlen     = awvalid ? 4'(burst_q - 5'd1) : 4'd0;
        wdata     = wvalid ? fifo_head : '0;
        wlast     = wvalid && last_beat;
        bram_addr = rd_addr_q;

        awid      = AXI_ID;
        wid       = AXI_ID;
        awsize    = SIZE_32B;
        awburst   = BURST_INCR;
        awlock    = 2'b00;
        awprot    = 3'b000;
        awcache   = CACHE_BUF_MOD;
        wstrb     = '1;
    end

    always_comb begin
        state_d      = state_q;
        start_d      = start;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        burst_d      = burst_q;
        beat_cnt_d   = beat_cnt_q;
        rd_left_d    = rd_left_q;
        rd_addr_d    = rd_addr_q;
        error_d      = error_q;

        start_edge   = start && !start_q;
        accept_start = (state_q == ST_IDLE) && start_edge;
        total_beats  = xfer_len[31:5];
        rem_next     = remaining_q - {22'd0, burst_q};
        addr_next    = addr_q + ADDR_W'({burst_q, 5'b00000});

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    error_d     = 1'b0;
                    addr_d      = {start_addr[ADDR_W-1:5], 5'b00000};
                    remaining_d = total_beats;
                    burst_d     = calc_burst(total_beats, start_addr[11:5]);
                    rd_left_d   = burst_d;
                    rd_addr_d   = '0;
                    beat_cnt_d  = 5'd0;
                    state_d     = (total_beats == 27'd0) ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (awready) begin
                    beat_cnt_d = 5'd0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (w_pop) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (last_beat) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (bvalid) begin
                    if (bresp != RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    addr_d      = addr_next;
                    remaining_d = rem_next;
                    burst_d     = calc_burst(rem_next, addr_next[11:5]);
                    rd_left_d   = burst_d;
                    state_d     = (rem_next == 27'd0) ? ST_DONE : ST_AW;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reads only happen in AW/W, where the case above leaves these alone.
        if (rd_issue) begin
            rd_left_d = rd_left_q - 5'd1;
            rd_addr_d = rd_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            rd_left_q   <= '0;
            rd_addr_q   <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_left_q   <= rd_left_d;
            rd_addr_q   <= rd_addr_d;
            error_q     <= error_d;
        end
    end

`ifdef F2S_WRITER_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [31:0] stat_cycles_q, stat_cycles_d;

    always_comb begin
        stat_beats_d  = stat_beats_q;
        stat_cycles_d = stat_cycles_q;
        if (accept_start) begin
            stat_beats_d  = '0;
            stat_cycles_d = '0;
        end else begin
            if (w_pop && (stat_beats_q != '1)) begin
                stat_beats_d = stat_beats_q + 32'd1;
            end
            if (busy && (stat_cycles_q != '1)) begin
                stat_cycles_d = stat_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats_q  <= '0;
            stat_cycles_q <= '0;
        end else begin
            stat_beats_q  <= stat_beats_d;
            stat_cycles_q <= stat_cycles_d;
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_cycles = stat_cycles_q;
`endif

endmodule

// File: tb/tb_f2s_axi_burst_writer.sv
`timescale 1ns/1ps
module tb_f2s_axi_burst_writer;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 32;
    localparam int BRAM_AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                start = 1'b0;
    logic [31:0]         start_addr = '0;
    logic [31:0]         xfer_len = '0;
    logic                done, busy, error;
    logic [BRAM_AW-1:0]  bram_addr;
    logic [DATA_W-1:0]   bram_rdata = '0;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [7:0]          awid;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [2:0]          awprot;
    logic [3:0]          awcache;
    logic                awvalid;
    logic                awready = 1'b0;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid;
    logic [7:0]          wid;
    logic                wready = 1'b0;
    logic [1:0]          bresp = 2'b00;
    logic [7:0]          bid = 8'h00;
    logic                bvalid = 1'b0;
    logic                bready;

    f2s_axi_burst_writer #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .BRAM_AW (BRAM_AW), .AXI_ID (8'h00)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .start_addr (start_addr),
        .xfer_len (xfer_len), .done (done), .busy (busy), .error (error),
        .bram_addr (bram_addr), .bram_rdata (bram_rdata),
        .awaddr (awaddr), .awlen (awlen), .awid (awid), .awsize (awsize),
        .awburst (awburst), .awlock (awlock), .awprot (awprot), .awcache (awcache),
        .awvalid (awvalid), .awready (awready),
        .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wid (wid),
        .wready (wready), .bresp (bresp), .bid (bid), .bvalid (bvalid), .bready (bready)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_aw_addr_q[$];
    logic [3:0]  exp_aw_len_q[$];
    logic [31:0] got_aw_addr_q[$];
    logic [3:0]  got_aw_len_q[$];
    logic [DATA_W-1:0] got_w_data_q[$];
    logic        got_w_last_q[$];

    // slave model knobs and state
    int  aw_delay  = 0;
    bit  w_rand    = 0;
    int  b_err_idx = -1;
    int  aw_wait   = 0;
    int  b_pending = 0;
    int  b_cnt     = 0;
    bit  b_hs_prev = 0;
    bit  b_check_next = 0;
    bit  aw_hold = 0;
    bit  w_hold  = 0;
    logic [31:0]       aw_hold_addr;
    logic [3:0]        aw_hold_len;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_hold_last;

    function automatic logic [DATA_W-1:0] bram_word(input logic [9:0] idx);
        logic [DATA_W-1:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*32 +: 32] = {8'hB0, 5'(j), 9'd0, idx};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // BRAM model: 1-cycle read latency
    always @(posedge clk) bram_rdata <= bram_word(bram_addr);

    // ---------------- AXI slave model (acts on falling edges) ----------------
    initial begin : axi_slave
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                aw_hold = 0; w_hold = 0; b_check_next = 0; b_hs_prev = 0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            end else begin
                if (b_check_next) begin
                    chk("b_to_next_aw_or_done", awvalid | done, 1'b1);
                    b_check_next = 0;
                end
                if (b_hs_prev) begin
                    bvalid = 1'b0; bresp = 2'b00; b_hs_prev = 0;
                end
                if (!bvalid && b_pending > 0) begin
                    bvalid = 1'b1;
                    bresp  = (b_cnt == b_err_idx) ? 2'b10 : 2'b00;
                    b_pending--;
                end
                if (aw_hold) begin
                    chk("aw_stall_valid", awvalid, 1'b1);
                    chk("aw_stall_addr", awaddr, aw_hold_addr);
                    chk("aw_stall_len", awlen, aw_hold_len);
                end
                if (w_hold) begin
                    chk("w_stall_valid", wvalid, 1'b1);
                    chk("w_stall_data", wdata, w_hold_data);
                    chk("w_stall_last", wlast, w_hold_last);
                end
                if (awvalid && wvalid) chk("aw_w_overlap", {awvalid, wvalid}, 2'b10);

                awready = (aw_delay == 0) ? 1'b1 : (awvalid && aw_wait >= aw_delay);
                wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                aw_hold = 0;
                w_hold  = 0;
                if (awvalid) begin
                    if (awready) begin
                        got_aw_addr_q.push_back(awaddr);
                        got_aw_len_q.push_back(awlen);
                        aw_wait = 0;
                    end else begin
                        aw_wait++;
                        aw_hold = 1; aw_hold_addr = awaddr; aw_hold_len = awlen;
                    end
                end
                if (wvalid) begin
                    if (wready) begin
                        got_w_data_q.push_back(wdata);
                        got_w_last_q.push_back(wlast);
                        if (wlast) b_pending++;
                    end else begin
                        w_hold = 1; w_hold_data = wdata; w_hold_last = wlast;
                    end
                end
                if (bvalid && bready) begin
                    b_hs_prev = 1; b_cnt++; b_check_next = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_model();
        got_aw_addr_q.delete(); got_aw_len_q.delete();
        got_w_data_q.delete();  got_w_last_q.delete();
        exp_aw_addr_q.delete(); exp_aw_len_q.delete();
        b_cnt = 0; b_pending = 0; b_hs_prev = 0; b_check_next = 0;
        bvalid = 1'b0; bresp = 2'b00; aw_wait = 0;
    endtask

    task automatic exp_burst(input logic [31:0] a, input logic [3:0] l);
        exp_aw_addr_q.push_back(a);
        exp_aw_len_q.push_back(l);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_reached"}, done, 1'b1);
    endtask

    task automatic check_xfer(input string tag, input int total_beats);
        int beat = 0;
        chk({tag, "_aw_count"}, got_aw_addr_q.size(), exp_aw_addr_q.size());
        for (int i = 0; i < exp_aw_addr_q.size(); i++) begin
            if (i < got_aw_addr_q.size()) begin
                chk($sformatf("%s_awaddr%0d", tag, i), got_aw_addr_q[i], exp_aw_addr_q[i]);
                chk($sformatf("%s_awlen%0d", tag, i), got_aw_len_q[i], exp_aw_len_q[i]);
            end
        end
        chk({tag, "_w_count"}, got_w_data_q.size(), total_beats);
        for (int i = 0; i < exp_aw_len_q.size(); i++) begin
            for (int j = 0; j <= int'(exp_aw_len_q[i]); j++) begin
                if (beat < got_w_data_q.size()) begin
                    chk($sformatf("%s_wdata%0d", tag, beat), got_w_data_q[beat], bram_word(10'(beat)));
                    chk($sformatf("%s_wlast%0d", tag, beat), got_w_last_q[beat], (j == int'(exp_aw_len_q[i])));
                end
                beat++;
            end
        end
        chk({tag, "_b_count"}, b_cnt, exp_aw_addr_q.size());
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int n;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // reset state
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_bram_addr", bram_addr, 10'd0);

        // T1: single 16-beat burst, ready tied high
        clear_model();
        aw_delay = 0; w_rand = 0; b_err_idx = -1;
        exp_burst(32'h2000_0000, 4'd15);
        start_addr = 32'h2000_0000; xfer_len = 32'd512; start = 1'b1;
        step();
        chk("t1_awvalid_n1", awvalid, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_awaddr", awaddr, 32'h2000_0000);
        chk("t1_awsize", awsize, 3'b101);
        chk("t1_awburst", awburst, 2'b01);
        chk("t1_awcache", awcache, 4'b0011);
        chk("t1_awlock_prot", {awlock, awprot}, 5'd0);
        chk("t1_ids", {awid, wid}, 16'h0000);
        step();
        chk("t1_wvalid_after_aw", wvalid, 1'b1);
        chk("t1_wstrb", wstrb, {32{1'b1}});
        wait_done("t1", 200);
        check_xfer("t1", 16);
        chk("t1_error", error, 1'b0);
        chk("t1_busy_done", busy, 1'b0);
        start = 1'b0;
        step();
        chk("t1_done_clear", done, 1'b0);

        // T2: 4 KB crossing -> 4 + 16 + 12 beats
        clear_model();
        exp_burst(32'h2000_0F80, 4'd3);
        exp_burst(32'h2000_1000, 4'd15);
        exp_burst(32'h2000_1200, 4'd11);
        start_addr = 32'h2000_0F80; xfer_len = 32'd1024; start = 1'b1;
        step();
        wait_done("t2", 400);
        check_xfer("t2", 32);
        start = 1'b0;
        step();

        // T3: zero length
        clear_model();
        start_addr = 32'h2000_0000; xfer_len = 32'd0; start = 1'b1;
        step();
        chk("t3_done_n1", done, 1'b1);
        chk("t3_awvalid", awvalid, 1'b0);
        chk("t3_busy", busy, 1'b0);
        repeat (3) step();
        chk("t3_done_held", done, 1'b1);
        chk("t3_no_aw", got_aw_addr_q.size(), 0);
        start = 1'b0;
        step();
        chk("t3_done_clear", done, 1'b0);

        // T4: 64 beats, awready delayed, wready random
        clear_model();
        aw_delay = 5; w_rand = 1;
        exp_burst(32'h3000_0000, 4'd15);
        exp_burst(32'h3000_0200, 4'd15);
        exp_burst(32'h3000_0400, 4'd15);
        exp_burst(32'h3000_0600, 4'd15);
        start_addr = 32'h3000_0000; xfer_len = 32'd2048; start = 1'b1;
        step();
        start = 1'b0;  // deassert mid-transfer: must be ignored
        wait_done("t4", 3000);
        check_xfer("t4", 64);
        chk("t4_error", error, 1'b0);
        step();

        // T5: SLVERR on 2nd burst of 4
        clear_model();
        aw_delay = 0; w_rand = 0; b_err_idx = 1;
        exp_burst(32'h4000_0000, 4'd15);
        exp_burst(32'h4000_0200, 4'd15);
        exp_burst(32'h4000_0400, 4'd15);
        exp_burst(32'h4000_0600, 4'd15);
        start_addr = 32'h4000_0000; xfer_len = 32'd2048; start = 1'b1;
        step();
        wait_done("t5", 600);
        chk("t5_error_set", error, 1'b1);
        check_xfer("t5", 64);
        start = 1'b0;
        step();
        chk("t5_error_sticky", error, 1'b1);
        clear_model();
        b_err_idx = -1;
        xfer_len = 32'd0; start = 1'b1;
        step();
        chk("t5_error_cleared", error, 1'b0);
        chk("t5_zero_done", done, 1'b1);
        start = 1'b0;
        step();

        // T6: reset mid-W, then a clean transfer
        clear_model();
        w_rand = 1;
        start_addr = 32'h5000_0000; xfer_len = 32'd512; start = 1'b1;
        n = 0;
        while (wvalid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("t6_reached_w", wvalid, 1'b1);
        step();
        step();
        chk("t6_busy_pre", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_awvalid", awvalid, 1'b0);
        chk("t6_rst_wvalid", wvalid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        start = 1'b0;
        step();
        step();
        clear_model();
        reset_n = 1'b1;
        step();
        exp_burst(32'h5000_0000, 4'd15);
        start = 1'b1;
        step();
        chk("t6_awvalid_after_rst", awvalid, 1'b1);
        wait_done("t6", 400);
        check_xfer("t6", 16);
        start = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
